// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT
  } i2c_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam int   BYTE_BITS   = 8;

endpackage

// File: rtl/i2c_reg_target_bus_cond.sv
// Synchronises SDA/SCL into clk and decodes SCL edges and START/STOP conditions.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic sda_i,
  input  logic scl_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic [1:0] pin_in;
  logic [1:0] pin_s;
  logic [1:0] pin_prev;

  assign pin_in = {scl_i, sda_i};

  // Index 0 is SDA, index 1 is SCL; both reset to the idle-bus level.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_reg <= 2'b11;
        prev_reg <= 1'b1;
      end else begin
        sync_reg <= {sync_reg[0], pin_in[gi]};
        prev_reg <= sync_reg[1];
      end
    end

    assign pin_s[gi]    = sync_reg[1];
    assign pin_prev[gi] = prev_reg;
  end

  assign sda_s    = pin_s[0];
  assign scl_rise = pin_s[1] & ~pin_prev[1];
  assign scl_fall = ~pin_s[1] & pin_prev[1];
  assign start    = pin_s[1] & pin_prev[1] & pin_prev[0] & ~pin_s[0];
  assign stop     = pin_s[1] & pin_prev[1] & ~pin_prev[0] & pin_s[0];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing NUM_REGS byte registers with pointer addressing,
// auto-incrementing burst writes and reads.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]            ADDRESS   = 7'd69,
  parameter int                    NUM_REGS  = 4,
  parameter logic [NUM_REGS*8-1:0] REG_RESET = '0,
  localparam int                   PTR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  btn_a,
  input  logic                  sda_i,
  input  logic                  scl_i,
  output logic                  sda_o,
  output logic                  scl_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe_o,
  output logic [PTR_W-1:0]      wr_index_o,
  output logic                  busy_o
);

  localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS);

  logic scl_rise, scl_fall, sda_s, start, stop;

  i2c_bus_cond u_bus_cond (
    .clk      (clk),
    .rst_n    (btn_a),
    .sda_i    (sda_i),
    .scl_i    (scl_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t       state_reg;
  logic [3:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic             rw_reg;
  logic [7:0]       regs_reg [NUM_REGS];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REGS - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!btn_a) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      ptr_reg     <= '0;
      rw_reg      <= 1'b0;
      sda_o       <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_index_o  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= REG_RESET[8*i +: 8];
    end else begin
      wr_strobe_o <= 1'b0;
      if (start) begin
        state_reg   <= ADDR;
        bit_cnt_reg <= '0;
        sda_o       <= 1'b0;
      end else if (stop) begin
        state_reg <= IDLE;
        sda_o     <= 1'b0;
      end else begin
        // Receive states share one shifter; the byte is acted on at the 8th SCL fall.
        if (scl_rise && (state_reg == ADDR || state_reg == PTR || state_reg == WDATA)
            && bit_cnt_reg != LAST_BIT) begin
          shift_reg   <= {shift_reg[6:0], sda_s};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
        case (state_reg)
          ADDR: if (scl_fall && bit_cnt_reg == LAST_BIT) begin
            rw_reg <= shift_reg[0];
            if (shift_reg[7:1] == ADDRESS) begin
              sda_o     <= 1'b1;
              state_reg <= ADDR_ACK;
            end else begin
              sda_o     <= 1'b0;
              state_reg <= WAIT;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (rw_reg == I2C_RW_READ) begin
              sda_o       <= ~regs_reg[ptr_reg][7];
              shift_reg   <= {regs_reg[ptr_reg][6:0], 1'b0};
              bit_cnt_reg <= 4'd1;
              state_reg   <= RDATA;
            end else begin
              sda_o       <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= PTR;
            end
          end
          PTR: if (scl_fall && bit_cnt_reg == LAST_BIT) begin
            if (int'(shift_reg) < NUM_REGS) begin
              ptr_reg   <= shift_reg[PTR_W-1:0];
              sda_o     <= 1'b1;
              state_reg <= PTR_ACK;
            end else begin
              sda_o     <= 1'b0;
              state_reg <= WAIT;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            sda_o       <= 1'b0;
            bit_cnt_reg <= '0;
            state_reg   <= WDATA;
          end
          WDATA: if (scl_fall && bit_cnt_reg == LAST_BIT) begin
            regs_reg[ptr_reg] <= shift_reg;
            wr_strobe_o       <= 1'b1;
            wr_index_o        <= ptr_reg;
            ptr_reg           <= ptr_next(ptr_reg);
            sda_o             <= 1'b1;
            state_reg         <= WDATA_ACK;
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt_reg == LAST_BIT) begin
              sda_o     <= 1'b0;
              state_reg <= RACK;
            end else begin
              sda_o       <= ~shift_reg[7];
              shift_reg   <= {shift_reg[6:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (!sda_s) ptr_reg <= ptr_next(ptr_reg);
              else        state_reg <= WAIT;
            end else if (scl_fall) begin
              sda_o       <= ~regs_reg[ptr_reg][7];
              shift_reg   <= {regs_reg[ptr_reg][6:0], 1'b0};
              bit_cnt_reg <= 4'd1;
              state_reg   <= RDATA;
            end
          end
          default: sda_o <= 1'b0;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    assign regs_o[8*gi +: 8] = regs_reg[gi];
  end

  assign scl_o  = 1'b0;
  assign busy_o = !(state_reg == IDLE || state_reg == ADDR || state_reg == WAIT);

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bus-level I2C controller model with a scoreboard of expected results.
module tb_i2c_reg_target;

  localparam int          NR      = 4;
  localparam logic [31:0] RST_VAL = 32'h44332211;
  localparam int          Q       = 10;

  logic        clk = 1'b0;
  logic        btn_a = 1'b0;
  logic        sda_drv = 1'b1;
  logic        scl_drv = 1'b1;
  logic        sda_o, scl_o, wr_strobe_o, busy_o;
  logic [31:0] regs_o;
  logic [1:0]  wr_index_o;
  wire         sda_line = sda_drv & ~sda_o;

  always #5 clk = ~clk;

  i2c_reg_target #(
    .ADDRESS   (7'd69),
    .NUM_REGS  (NR),
    .REG_RESET (RST_VAL)
  ) dut (
    .clk         (clk),
    .btn_a       (btn_a),
    .sda_i       (sda_line),
    .scl_i       (scl_drv),
    .sda_o       (sda_o),
    .scl_o       (scl_o),
    .regs_o      (regs_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_index_o  (wr_index_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mon_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mregs[NR];
  int          mptr = 0;

  always @(negedge clk)
    if (wr_strobe_o) mon_q.push_back({22'b0, wr_index_o, regs_o[8*wr_index_o +: 8]});

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_underflow: observed %0h required <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] mpack();
    return {mregs[3], mregs[2], mregs[1], mregs[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = RST_VAL[8*i +: 8];
    mptr = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    tick(Q);
    scl_drv = 1'b1; tick(2*Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    b = sda_line;   tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  // Byte with an expected ACK/NACK.
  task automatic send(input string tag, input logic [7:0] d, input logic exp_ack);
    logic ack;
    sb_push(tag, {31'b0, exp_ack});
    write_byte(d, ack);
    sb_check({31'b0, ack});
  endtask

  // Data byte written through the model pointer, checked against the strobe monitor.
  task automatic send_data(input logic [7:0] d);
    send("data_ack", d, 1'b1);
    sb_push("strobe", {22'b0, 2'(mptr), d});
    mregs[mptr] = d;
    mptr = (mptr + 1) % NR;
    if (mon_q.size() != 0) sb_check(mon_q.pop_front());
    else sb_check(32'hxxxxxxxx);
  endtask

  task automatic check_quiet(input string tag);
    sb_push({tag, "_regs"}, mpack());
    sb_check(regs_o);
    sb_push({tag, "_extra_strobes"}, 0);
    sb_check(mon_q.size());
    sb_push({tag, "_busy"}, 0);
    sb_check({31'b0, busy_o});
  endtask

  initial begin
    logic [7:0] rd;
    model_reset();

    // Reset state
    tick(5);
    sb_push("rst_regs", RST_VAL);       sb_check(regs_o);
    sb_push("rst_sda", 0);              sb_check({31'b0, sda_o});
    sb_push("rst_busy", 0);             sb_check({31'b0, busy_o});
    sb_push("rst_strobe", 0);           sb_check({31'b0, wr_strobe_o});
    sb_push("rst_index", 0);            sb_check({30'b0, wr_index_o});
    sb_push("scl_o", 0);                sb_check({31'b0, scl_o});
    btn_a = 1'b1;
    tick(Q);

    // Single write 0x45 to reg 1
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    sb_push("busy_after_ack", 1);       sb_check({31'b0, busy_o});
    send("ptr_ack", 8'h01, 1'b1);
    mptr = 1;
    send_data(8'h45);
    bus_stop();
    check_quiet("wr1");

    // Address mismatch: NACK, following bytes ignored
    bus_start();
    send("mismatch_nack", 8'h40, 1'b0);
    sb_push("mismatch_busy", 0);        sb_check({31'b0, busy_o});
    send("ignored_nack", 8'h01, 1'b0);
    send("ignored_nack2", 8'hEE, 1'b0);
    bus_stop();
    check_quiet("mismatch");

    // Burst write with wrap: pointer 3, A1 A2 A3
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_ack", 8'h03, 1'b1);
    mptr = 3;
    send_data(8'hA1);
    send_data(8'hA2);
    send_data(8'hA3);
    bus_stop();
    check_quiet("burst");

    // Pointer 2, repeated START, read two bytes (ACK then NACK)
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_ack", 8'h02, 1'b1);
    mptr = 2;
    bus_start();
    send("raddr_ack", 8'h8B, 1'b1);
    sb_push("rd_byte0", {24'b0, mregs[mptr]});
    read_byte(rd);
    sb_check({24'b0, rd});
    write_bit(1'b0);
    mptr = (mptr + 1) % NR;
    sb_push("rd_byte1", {24'b0, mregs[mptr]});
    read_byte(rd);
    sb_check({24'b0, rd});
    write_bit(1'b1);
    sb_push("rd_released", 0);          sb_check({31'b0, sda_o});
    bus_stop();
    check_quiet("read");

    // Abort: STOP after 4 data bits, then a full write succeeds
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_ack", 8'h00, 1'b1);
    mptr = 0;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    check_quiet("abort");
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_ack", 8'h00, 1'b1);
    mptr = 0;
    send_data(8'h5A);
    bus_stop();
    check_quiet("after_abort");

    // Out-of-range pointer: NACK, pointer keeps its value (observed by reading)
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_oor_nack", 8'h07, 1'b0);
    bus_stop();
    bus_start();
    send("raddr_ack", 8'h8B, 1'b1);
    sb_push("rd_ptr_kept", {24'b0, mregs[mptr]});
    read_byte(rd);
    sb_check({24'b0, rd});
    write_bit(1'b1);
    bus_stop();
    check_quiet("oor");

    // Reset while the target holds an ACK
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 3 || i == 1);
    sb_push("ack_held", 1);             sb_check({31'b0, sda_o});
    btn_a = 1'b0;
    tick(1);
    model_reset();
    sb_push("rst_mid_sda", 0);          sb_check({31'b0, sda_o});
    sb_push("rst_mid_regs", RST_VAL);   sb_check(regs_o);
    sb_push("rst_mid_busy", 0);         sb_check({31'b0, busy_o});
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    btn_a = 1'b1;   tick(Q);

    // Recovery after reset
    bus_start();
    send("addr_ack", 8'h8A, 1'b1);
    send("ptr_ack", 8'h02, 1'b1);
    mptr = 2;
    send_data(8'h77);
    bus_stop();
    check_quiet("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
